// File: rtl/ql_kbd_pkg.sv
// Shared definitions for the QL keyboard buffer: PS/2 field positions,
// modifier scancodes, modifier bit order, FIFO entry layout, QL key codes.
package ql_kbd_pkg;

  localparam int PS2_TOGGLE  = 10;
  localparam int PS2_PRESSED = 9;
  localparam int PS2_EXT     = 8;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;

  typedef enum logic [1:0] {
    MOD_SHIFT = 2'd0,
    MOD_CTRL  = 2'd1,
    MOD_ALT   = 2'd2
  } mod_bit_e;

  typedef struct packed {
    logic [2:0] mod;
    logic [5:0] code;
  } kb_entry_t;

  localparam logic [5:0] QL_K_A     = 6'd28;
  localparam logic [5:0] QL_K_ENTER = 6'd48;
  localparam logic [5:0] QL_K_LEFT  = 6'd49;
  localparam logic [5:0] QL_K_UP    = 6'd50;
  localparam logic [5:0] QL_K_ESC   = 6'd51;
  localparam logic [5:0] QL_K_RIGHT = 6'd52;
  localparam logic [5:0] QL_K_SPACE = 6'd54;
  localparam logic [5:0] QL_K_DOWN  = 6'd55;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

endpackage

// File: rtl/ql_keybuf_if.sv
// IPC-side view of the key buffer: pop strobe in, FIFO head and status out.
// master = IPC (zx8302), slave = key buffer.
interface ql_keybuf_if #(
  parameter int DEPTH = 8
);
  logic                   rd;
  logic                   key_valid;
  logic [5:0]             key_code;
  logic [2:0]             key_mod;
  logic                   overflow;
  logic [$clog2(DEPTH):0] count;

  modport master (output rd, input key_valid, key_code, key_mod, overflow, count);
  modport slave  (input rd, output key_valid, key_code, key_mod, overflow, count);
endinterface

// File: rtl/ql_keymap.sv
// Registered PS/2 set-2 to QL key code lookup; {ext, scancode} in, {hit, code} out.
module ql_keymap
  import ql_kbd_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [8:0] scan_i,
  output logic       hit_o,
  output logic [5:0] code_o
);

  logic       hit_d, hit_q;
  logic [5:0] code_d, code_q;

  // table decode; anything not listed is a miss
  always_comb begin
    hit_d  = 1'b1;
    code_d = 6'd0;
    case (scan_i)
      9'h01C:  code_d = QL_K_A;
      9'h029:  code_d = QL_K_SPACE;
      9'h05A:  code_d = QL_K_ENTER;
      9'h076:  code_d = QL_K_ESC;
      9'h16B:  code_d = QL_K_LEFT;
      9'h174:  code_d = QL_K_RIGHT;
      9'h175:  code_d = QL_K_UP;
      9'h172:  code_d = QL_K_DOWN;
      default: hit_d  = 1'b0;
    endcase
  end

  // result register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hit_q  <= 1'b0;
      code_q <= 6'd0;
    end else begin
      hit_q  <= hit_d;
      code_q <= code_d;
    end
  end

  assign hit_o  = hit_q;
  assign code_o = code_q;

endmodule

// File: rtl/ql_keybuf.sv
// PS/2 key events -> QL key codes with modifier state, queued in a
// first-word-fall-through FIFO popped by the ZX8302 IPC.
// Pipeline: detect (N) -> lookup (N+1) -> push (N+2).
// Optional autorepeat: define QL_KBD_AUTOREPEAT_EN.
module ql_keybuf
  import ql_kbd_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int REP_DELAY = 65536,
  parameter int REP_RATE  = 6554
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        tick,
  ql_keybuf_if.slave  ipc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic       tog_q;
  logic       ev_det, ev_press;
  logic [8:0] ev_scan;
  logic       is_lsh, is_rsh, is_ctrl, is_alt, is_mod;
  logic       lsh_q, rsh_q, ctrl_q, alt_q;
  logic [2:0] mod_cur;

  logic       s1_vld_q, s1_press_q;
  logic [8:0] s1_scan_q;
  logic [2:0] s1_mod_q;
  logic       s2_vld_q, s2_press_q;
  logic [8:0] s2_scan_q;
  logic [2:0] s2_mod_q;
  logic       s2_hit;
  logic [5:0] s2_code;

  logic          pipe_push, push, pop, full, wr_en;
  kb_entry_t     push_entry, head;
  kb_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  assign ev_det   = ps2_key[PS2_TOGGLE] ^ tog_q;
  assign ev_press = ps2_key[PS2_PRESSED];
  assign ev_scan  = ps2_key[PS2_EXT:0];
  assign is_lsh   = !ev_scan[8] && (ev_scan[7:0] == SC_LSHIFT);
  assign is_rsh   = !ev_scan[8] && (ev_scan[7:0] == SC_RSHIFT);
  assign is_ctrl  = ev_scan[7:0] == SC_CTRL;
  assign is_alt   = ev_scan[7:0] == SC_ALT;
  assign is_mod   = is_lsh | is_rsh | is_ctrl | is_alt;

  assign mod_cur[MOD_SHIFT] = lsh_q | rsh_q;
  assign mod_cur[MOD_CTRL]  = ctrl_q;
  assign mod_cur[MOD_ALT]   = alt_q;

  // toggle tracking (reloaded in reset so no event fires on exit) and modifier state
  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_key[PS2_TOGGLE];
    if (reset) begin
      lsh_q  <= 1'b0;
      rsh_q  <= 1'b0;
      ctrl_q <= 1'b0;
      alt_q  <= 1'b0;
    end else if (ev_det) begin
      if (is_lsh)  lsh_q  <= ev_press;
      if (is_rsh)  rsh_q  <= ev_press;
      if (is_ctrl) ctrl_q <= ev_press;
      if (is_alt)  alt_q  <= ev_press;
    end
  end

  // detect and lookup stages; the modifier snapshot travels with the event
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_press_q <= 1'b0;
      s1_scan_q  <= 9'd0;
      s1_mod_q   <= 3'd0;
      s2_vld_q   <= 1'b0;
      s2_press_q <= 1'b0;
      s2_scan_q  <= 9'd0;
      s2_mod_q   <= 3'd0;
    end else begin
      s1_vld_q   <= ev_det & ~is_mod;
      s1_press_q <= ev_press;
      s1_scan_q  <= ev_scan;
      s1_mod_q   <= mod_cur;
      s2_vld_q   <= s1_vld_q;
      s2_press_q <= s1_press_q;
      s2_scan_q  <= s1_scan_q;
      s2_mod_q   <= s1_mod_q;
    end
  end

  ql_keymap u_keymap (
    .clk_sys (clk_sys),
    .reset   (reset),
    .scan_i  (s1_scan_q),
    .hit_o   (s2_hit),
    .code_o  (s2_code)
  );

  assign pipe_push = s2_vld_q & s2_press_q & s2_hit;

`ifdef QL_KBD_AUTOREPEAT_EN
  rep_state_e st_q, st_d;
  logic [16:0] cnt_q, cnt_val;
  logic [8:0]  rep_scan_q;
  logic [5:0]  rep_code_q;
  logic        stored_rel, expire, rep_fire, cnt_load, rep_push;

  assign stored_rel = s2_vld_q & ~s2_press_q & (s2_scan_q == rep_scan_q);
  assign expire     = tick & (cnt_q <= 17'd1);

  // repeat state register
  always_ff @(posedge clk_sys) begin
    if (reset) st_q <= ST_IDLE;
    else       st_q <= st_d;
  end

  // a fresh press always wins; release only matters for the held key
  always_comb begin
    st_d = st_q;
    if (pipe_push)                             st_d = ST_DELAY;
    else if (stored_rel && st_q != ST_IDLE)    st_d = ST_IDLE;
    else if (st_q != ST_IDLE && expire)        st_d = ST_REPEAT;
  end

  // counter load and repeat request
  always_comb begin
    rep_fire = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = 17'd0;
    if (pipe_push) begin
      cnt_load = 1'b1;
      cnt_val  = 17'(REP_DELAY);
    end else if (!stored_rel && st_q != ST_IDLE && expire) begin
      rep_fire = 1'b1;
      cnt_load = 1'b1;
      cnt_val  = 17'(REP_RATE);
    end
  end

  // a repeat only goes in when the IPC has drained the queue
  assign rep_push = rep_fire & (count_q == '0) & ~pipe_push;

  // tick down-counter and held-key capture
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q      <= 17'd0;
      rep_scan_q <= 9'd0;
      rep_code_q <= 6'd0;
    end else begin
      if (cnt_load) cnt_q <= cnt_val;
      else if (tick && st_q != ST_IDLE && cnt_q != 17'd0) cnt_q <= cnt_q - 17'd1;
      if (pipe_push) begin
        rep_scan_q <= s2_scan_q;
        rep_code_q <= s2_code;
      end
    end
  end

  // pipeline entry has priority over a repeat
  always_comb begin
    push       = pipe_push | rep_push;
    push_entry = pipe_push ? kb_entry_t'{mod: s2_mod_q, code: s2_code}
                           : kb_entry_t'{mod: mod_cur, code: rep_code_q};
  end
`else
  localparam int unused_rep = REP_DELAY + REP_RATE;
  logic unused_sig;
  assign unused_sig = ^{tick, s2_scan_q};

  // pipeline is the only source of entries
  always_comb begin
    push       = pipe_push;
    push_entry = kb_entry_t'{mod: s2_mod_q, code: s2_code};
  end
`endif

  assign full  = count_q == CW'(DEPTH);
  assign pop   = ipc.rd & (count_q != '0);
  assign wr_en = push & (~full | pop);

  // occupancy and sticky overflow; overflow drops once a pop empties the queue
  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (pop && !wr_en) count_d = count_q - CW'(1);
    ovf_d = ovf_q;
    if (push && full && !pop)                        ovf_d = 1'b1;
    else if (pop && !wr_en && count_q == CW'(1))     ovf_d = 1'b0;
  end

  // storage and pointers; when full with a pop, the write lands in the freed head slot
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wp_q] <= push_entry;
        wp_q        <= wp_q + AW'(1);
      end
      if (pop) rp_q <= rp_q + AW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign head          = mem_q[rp_q];
  assign ipc.key_valid = count_q != '0;
  assign ipc.key_code  = head.code;
  assign ipc.key_mod   = head.mod;
  assign ipc.overflow  = ovf_q;
  assign ipc.count     = count_q;

endmodule

// File: tb/tb_ql_keybuf.sv
// Bench for ql_keybuf: directed scenarios plus random key/pop traffic,
// compared each cycle against a queue-based reference model.
module tb_ql_keybuf;
  import ql_kbd_pkg::*;

  localparam int DEPTH = 8;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        tick;
  logic [10:0] ps2_key;

  ql_keybuf_if #(.DEPTH(DEPTH)) ipc ();

  ql_keybuf #(.DEPTH(DEPTH), .REP_DELAY(4), .REP_RATE(2)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ps2_key (ps2_key),
    .tick    (tick),
    .ipc     (ipc)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_vec, n_err;
  bit          chk_en;
  bit [10:0]   cur_key;

  // reference model state
  bit [8:0]    m_q[$];
  bit          m_ovf, m_tog, m_lsh, m_rsh, m_ctrl, m_alt;
  bit          d0_v, d1_v;
  bit [8:0]    d0_e, d1_e;

  bit [8:0] pool [16] = '{9'h01C, 9'h029, 9'h05A, 9'h16B, 9'h076, 9'h175, 9'h174, 9'h172,
                          9'h012, 9'h059, 9'h014, 9'h114, 9'h011, 9'h111, 9'h000, 9'h06B};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit [6:0] ref_map(input bit [8:0] sc);
    case (sc)
      9'h01C:  return {1'b1, 6'd28};
      9'h029:  return {1'b1, 6'd54};
      9'h05A:  return {1'b1, 6'd48};
      9'h16B:  return {1'b1, 6'd49};
      9'h076:  return {1'b1, 6'd51};
      9'h175:  return {1'b1, 6'd50};
      9'h174:  return {1'b1, 6'd52};
      9'h172:  return {1'b1, 6'd55};
      default: return 7'd0;
    endcase
  endfunction

  // one clock edge of the reference: an event seen at edge k lands in the queue at edge k+2
  task automatic model_clock(input bit rst_v, input bit [10:0] key, input bit rd_v);
    bit       due_v;
    bit [8:0] due_e;
    bit [6:0] lk;
    bit [2:0] mods;
    bit       popped;
    if (rst_v) begin
      m_q.delete();
      m_ovf = 0; m_tog = key[10];
      m_lsh = 0; m_rsh = 0; m_ctrl = 0; m_alt = 0;
      d0_v = 0; d1_v = 0;
      return;
    end
    due_v = d1_v; due_e = d1_e;
    d1_v = d0_v; d1_e = d0_e; d0_v = 0;
    if (key[10] != m_tog) begin
      m_tog = key[10];
      mods = {m_alt, m_ctrl, m_lsh | m_rsh};
      if (key[8:0] == 9'h012)      m_lsh  = key[9];
      else if (key[8:0] == 9'h059) m_rsh  = key[9];
      else if (key[7:0] == 8'h14)  m_ctrl = key[9];
      else if (key[7:0] == 8'h11)  m_alt  = key[9];
      else begin
        lk = ref_map(key[8:0]);
        if (key[9] && lk[6]) begin
          d0_v = 1;
          d0_e = {mods, lk[5:0]};
        end
      end
    end
    popped = rd_v && (m_q.size() != 0);
    if (popped) void'(m_q.pop_front());
    if (due_v) begin
      if (m_q.size() < DEPTH) m_q.push_back(due_e);
      else m_ovf = 1;
    end
    if (popped && m_q.size() == 0) m_ovf = 0;
  endtask

  task automatic check_model();
    bit [8:0] hd;
    check_eq("valid", ipc.key_valid, m_q.size() != 0);
    check_eq("count", ipc.count, m_q.size());
    check_eq("overflow", ipc.overflow, m_ovf);
    if (m_q.size() != 0) begin
      hd = m_q[0];
      check_eq("code", ipc.key_code, hd[5:0]);
      check_eq("mod", ipc.key_mod, hd[8:6]);
    end
  endtask

  task automatic cycle(input bit rst_v, input bit rd_v, input bit tk);
    reset = rst_v; ps2_key = cur_key; ipc.rd = rd_v; tick = tk;
    @(posedge clk_sys);
    model_clock(rst_v, cur_key, rd_v);
    @(negedge clk_sys);
    if (chk_en) check_model();
  endtask

  task automatic key_ev(input bit [8:0] sc, input bit pr);
    cur_key = {~cur_key[10], pr, sc};
    cycle(0, 0, 0);
  endtask

  task automatic idle(input int n, input bit rd_v);
    repeat (n) cycle(0, rd_v, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; chk_en = 1;
    cur_key = 11'h41C;
    reset = 1; ps2_key = cur_key; ipc.rd = 0; tick = 0;
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    check_eq("rst_valid", ipc.key_valid, 0);
    check_eq("rst_code", ipc.key_code, 0);
    check_eq("rst_mod", ipc.key_mod, 0);
    check_eq("rst_count", ipc.count, 0);
    check_eq("rst_ovf", ipc.overflow, 0);
    idle(3, 0);
    check_eq("no_spurious", ipc.count, 0);

    // press A: three cycles to key_valid
    key_ev(9'h01C, 1);
    check_eq("lat_c1", ipc.key_valid, 0);
    idle(1, 0);
    check_eq("lat_c2", ipc.key_valid, 0);
    idle(1, 0);
    check_eq("lat_c3", ipc.key_valid, 1);
    check_eq("a_code", ipc.key_code, 28);
    check_eq("a_mod", ipc.key_mod, 0);
    check_eq("a_count", ipc.count, 1);
    key_ev(9'h01C, 0);
    idle(3, 0);
    check_eq("release_count", ipc.count, 1);
    idle(1, 1);
    check_eq("pop_empty", ipc.key_valid, 0);

    // shift + A
    key_ev(9'h012, 1);
    key_ev(9'h01C, 1);
    idle(3, 0);
    check_eq("sh_code", ipc.key_code, 28);
    check_eq("sh_mod", ipc.key_mod, 3'b001);
    idle(1, 1);
    check_eq("sh_pop", ipc.key_valid, 0);
    key_ev(9'h012, 0);
    key_ev(9'h01C, 0);
    idle(3, 0);

    // overflow with nine SPACE presses
    for (int i = 0; i < 9; i++) key_ev(9'h029, 1);
    idle(3, 0);
    check_eq("ovf_count", ipc.count, 8);
    check_eq("ovf_set", ipc.overflow, 1);
    check_eq("ovf_head", ipc.key_code, 54);
    idle(7, 1);
    check_eq("ovf_held", ipc.overflow, 1);
    idle(1, 1);
    check_eq("ovf_clear", ipc.overflow, 0);
    check_eq("ovf_drained", ipc.count, 0);

    // full: push and pop on the same edge
    for (int i = 0; i < 8; i++) key_ev(9'h029, 1);
    idle(3, 0);
    check_eq("full_count", ipc.count, 8);
    key_ev(9'h05A, 1);
    idle(1, 0);
    idle(1, 1);
    check_eq("fullrw_count", ipc.count, 8);
    check_eq("fullrw_ovf", ipc.overflow, 0);
    idle(7, 1);
    check_eq("tail_code", ipc.key_code, 48);
    check_eq("tail_count", ipc.count, 1);
    idle(1, 1);

    // unmapped and extended keys
    key_ev(9'h000, 1);
    idle(3, 0);
    check_eq("unmapped_count", ipc.count, 0);
    check_eq("unmapped_ovf", ipc.overflow, 0);
    key_ev(9'h16B, 1);
    idle(2, 0);
    check_eq("left_code", ipc.key_code, 49);
    idle(1, 1);
    key_ev(9'h16B, 0);

    // reset in the middle of an event
    key_ev(9'h01C, 1);
    cycle(1, 0, 0);
    idle(3, 0);
    check_eq("midrst_count", ipc.count, 0);

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      bit tk;
      tk = 0;
`ifndef QL_KBD_AUTOREPEAT_EN
      tk = ($urandom_range(0, 3) == 0);
`endif
      if ($urandom_range(0, 9) < 3)
        cur_key = {~cur_key[10], 1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)]};
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 4), tk);
    end

`ifdef QL_KBD_AUTOREPEAT_EN
    // autorepeat with REP_DELAY=4, REP_RATE=2: entries at ticks 0, 4, 6, 8
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk_en = 0;
    key_ev(9'h01C, 1);
    idle(3, 0);
    check_eq("ar_t0_valid", ipc.key_valid, 1);
    check_eq("ar_t0_code", ipc.key_code, 28);
    idle(1, 1);
    for (int t = 1; t <= 12; t++) begin
      if (t == 9) begin
        key_ev(9'h01C, 0);
        idle(3, 0);
      end
      cycle(0, 0, 1);
      check_eq($sformatf("ar_tick%0d", t), ipc.key_valid, (t == 4 || t == 6 || t == 8));
      if (ipc.key_valid) begin
        check_eq($sformatf("ar_code%0d", t), ipc.key_code, 28);
        idle(1, 1);
      end
      idle(2, 0);
    end
    chk_en = 1;
    cycle(1, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
